qam_tx_sequencer: RTL and testbench

// Frame-level controller for the QAM4 transmit path. Takes payload bytes over a valid/ready handshake,

---
 rtl/qam_pkg.sv | 30 +++
 rtl/qam_if.sv | 34 +++
 rtl/qam_sym_timer.sv | 49 ++++
 rtl/qam_tx_sequencer.sv | 239 +++++++++++++++++++++++
 tb/tb_qam_tx_sequencer.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/qam_pkg.sv
// Shared types and constants for the QAM4 transmit sequencer.
package qam_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD,
    ST_TAIL
  } state_t;

  // Dibit sent while nothing is being transmitted (and during the tail flush).
  localparam logic [1:0] SYM_IDLE  = 2'b00;
  // Preamble alternates between these, starting with PRE_SYM_A.
  localparam logic [1:0] PRE_SYM_A = 2'b10;
  localparam logic [1:0] PRE_SYM_B = 2'b01;

  // Dibit idx of an 8-bit word, MSB pair first.
  function automatic logic [1:0] sync_sym(input logic [7:0] word, input logic [1:0] idx);
    logic [1:0] d;
    case (idx)
      2'd0:    d = word[7:6];
      2'd1:    d = word[5:4];
      2'd2:    d = word[3:2];
      default: d = word[1:0];
    endcase
    return d;
  endfunction

endpackage

// File: rtl/qam_if.sv
// Frame request, payload stream and mixer/LUT drive signals of the sequencer.
// Handshake: a payload byte moves on every clk edge where s_valid && s_ready are both
// high; s_valid/s_data are held by the source until taken, s_ready does not depend on s_valid.
interface qam_if;
  import qam_pkg::*;

  logic       start;
  logic [7:0] frame_len;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       sample_en;
  logic       lut_phase_rst;
  logic [1:0] sym_out;
  logic       sym_strobe;
  logic       tx_active;
  logic       busy;
  logic       frame_done;
  logic       underrun;
  state_t     dbg_state;

  modport master (
    output start, frame_len, s_data, s_valid,
    input  s_ready, sample_en, lut_phase_rst, sym_out, sym_strobe,
    input  tx_active, busy, frame_done, underrun, dbg_state
  );

  modport slave (
    input  start, frame_len, s_data, s_valid,
    output s_ready, sample_en, lut_phase_rst, sym_out, sym_strobe,
    output tx_active, busy, frame_done, underrun, dbg_state
  );

endinterface

// File: rtl/qam_sym_timer.sv
// Sample-tick prescaler and per-symbol sample counter.
// sample_en is registered so it is 0 while reset is held; after that it is high exactly
// when tick_cnt == PRESCALE. clr restarts both counters so a frame starts phase-aligned.
module qam_sym_timer #(
  parameter int PRESCALE = 0,
  parameter int SPS      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic sample_en,
  output logic sym_boundary
);

  localparam int TW = (PRESCALE > 0) ? $clog2(PRESCALE + 1) : 1;
  localparam int SW = $clog2(SPS);

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] tick_nxt;
  logic [SW-1:0] samp_cnt;

  // Next prescaler count: wrap at PRESCALE, restart on clear.
  always_comb begin
    tick_nxt = tick_cnt + 1'b1;
    if (clr || tick_cnt == TW'(PRESCALE)) begin
      tick_nxt = '0;
    end
  end

  // Prescaler, registered sample tick and sample-within-symbol counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt  <= '0;
      sample_en <= 1'b0;
      samp_cnt  <= '0;
    end else begin
      tick_cnt  <= tick_nxt;
      sample_en <= (tick_nxt == TW'(PRESCALE));
      if (clr) begin
        samp_cnt <= '0;
      end else if (sample_en) begin
        samp_cnt <= (samp_cnt == SW'(SPS - 1)) ? '0 : samp_cnt + 1'b1;
      end
    end
  end

  assign sym_boundary = sample_en && (samp_cnt == SW'(SPS - 1));

endmodule

// File: rtl/qam_tx_sequencer.sv
// Frame sequencer for the QAM4 transmitter: preamble, sync word, flow-controlled payload
// and a tail flush, one dibit per symbol period.
module qam_tx_sequencer
  import qam_pkg::*;
#(
  parameter int         PRESCALE      = 0,
  parameter int         SPS           = 16,
  parameter int         PREAMBLE_SYMS = 8,
  parameter logic [7:0] SYNC_WORD     = 8'hD3,
  parameter int         TAIL_SYMS     = 2
) (
  input logic  clk,
  input logic  rst,
  qam_if.slave bus
);

  state_t     state_q, state_d;
  logic [7:0] sym_cnt_q, sym_cnt_d;   // symbol index within the current state / byte
  logic [7:0] len_q, len_d;           // latched frame_len
  logic [7:0] taken_q, taken_d;       // bytes accepted on the stream
  logic [7:0] sent_q, sent_d;         // bytes moved into the shifter
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] sym_q, sym_d;
  logic       strobe_q, strobe_d;
  logic       lut_q, lut_d;
  logic       done_q, done_d;
  logic       ur_q, ur_d;

  logic       timer_clr;
  logic       sample_en;
  logic       sym_bnd;
  logic       s_ready;
  logic       accept;
  logic       want_byte;
  logic       take_accept;
  logic       byte_avail;
  logic [7:0] byte_val;

  qam_sym_timer #(
    .PRESCALE (PRESCALE),
    .SPS      (SPS)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .clr          (timer_clr),
    .sample_en    (sample_en),
    .sym_boundary (sym_bnd)
  );

  assign s_ready    = (state_q == ST_SYNC || state_q == ST_PAYLOAD) && !hold_full_q &&
                      (taken_q < len_q);
  assign accept     = bus.s_valid && s_ready;
  // A byte arriving on the very clk of a byte boundary is passed straight to the shifter.
  assign byte_avail = hold_full_q || accept;
  assign byte_val   = hold_full_q ? hold_q : bus.s_data;

  // Next-state, datapath and pulse outputs; every change except leaving IDLE waits for a boundary.
  always_comb begin
    state_d     = state_q;
    sym_cnt_d   = sym_cnt_q;
    len_d       = len_q;
    taken_d     = taken_q;
    sent_d      = sent_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    sym_d       = sym_q;
    strobe_d    = 1'b0;
    lut_d       = 1'b0;
    done_d      = 1'b0;
    ur_d        = 1'b0;
    timer_clr   = 1'b0;
    want_byte   = 1'b0;
    take_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sym_d = SYM_IDLE;
        if (bus.start) begin
          state_d     = ST_PREAMBLE;
          len_d       = bus.frame_len;
          lut_d       = 1'b1;
          timer_clr   = 1'b1;
          sym_d       = PRE_SYM_A;
          strobe_d    = 1'b1;
          sym_cnt_d   = '0;
          taken_d     = '0;
          sent_d      = '0;
          hold_full_d = 1'b0;
        end
      end
      ST_PREAMBLE: begin
        if (sym_bnd) begin
          strobe_d = 1'b1;
          if (sym_cnt_q == 8'(PREAMBLE_SYMS - 1)) begin
            state_d   = ST_SYNC;
            sym_cnt_d = '0;
            sym_d     = sync_sym(SYNC_WORD, 2'd0);
          end else begin
            sym_cnt_d = sym_cnt_q + 8'd1;
            sym_d     = sym_cnt_q[0] ? PRE_SYM_A : PRE_SYM_B;
          end
        end
      end
      ST_SYNC: begin
        if (sym_bnd) begin
          if (sym_cnt_q == 8'd3) begin
            if (len_q == 8'd0) begin
              state_d   = ST_TAIL;
              sym_cnt_d = '0;
              sym_d     = SYM_IDLE;
              strobe_d  = 1'b1;
            end else begin
              want_byte = 1'b1;
            end
          end else begin
            sym_cnt_d = sym_cnt_q + 8'd1;
            sym_d     = sync_sym(SYNC_WORD, sym_cnt_q[1:0] + 2'd1);
            strobe_d  = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (sym_bnd) begin
          if (sym_cnt_q == 8'd3) begin
            if (sent_q == len_q) begin
              state_d   = ST_TAIL;
              sym_cnt_d = '0;
              sym_d     = SYM_IDLE;
              strobe_d  = 1'b1;
            end else begin
              want_byte = 1'b1;
            end
          end else begin
            sym_cnt_d = sym_cnt_q + 8'd1;
            sym_d     = shift_q[7:6];
            shift_d   = {shift_q[5:0], 2'b00};
            strobe_d  = 1'b1;
          end
        end
      end
      ST_TAIL: begin
        if (sym_bnd) begin
          if (sym_cnt_q == 8'(TAIL_SYMS - 1)) begin
            state_d   = ST_IDLE;
            sym_cnt_d = '0;
            sym_d     = SYM_IDLE;
            done_d    = 1'b1;
          end else begin
            sym_cnt_d = sym_cnt_q + 8'd1;
            sym_d     = SYM_IDLE;
            strobe_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        sym_d   = SYM_IDLE;
      end
    endcase

    // Byte boundary: load the next payload byte, or abandon the payload on underrun.
    if (want_byte) begin
      strobe_d  = 1'b1;
      sym_cnt_d = '0;
      if (byte_avail) begin
        state_d = ST_PAYLOAD;
        sym_d   = byte_val[7:6];
        shift_d = {byte_val[5:0], 2'b00};
        sent_d  = sent_q + 8'd1;
        if (hold_full_q) begin
          hold_full_d = 1'b0;
        end else begin
          take_accept = 1'b1;
        end
      end else begin
        state_d = ST_TAIL;
        sym_d   = SYM_IDLE;
        ur_d    = 1'b1;
      end
    end

    if (accept) begin
      taken_d = taken_q + 8'd1;
      if (!take_accept) begin
        hold_d      = bus.s_data;
        hold_full_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sym_cnt_q   <= '0;
      len_q       <= '0;
      taken_q     <= '0;
      sent_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      sym_q       <= SYM_IDLE;
      strobe_q    <= 1'b0;
      lut_q       <= 1'b0;
      done_q      <= 1'b0;
      ur_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_cnt_q   <= sym_cnt_d;
      len_q       <= len_d;
      taken_q     <= taken_d;
      sent_q      <= sent_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      sym_q       <= sym_d;
      strobe_q    <= strobe_d;
      lut_q       <= lut_d;
      done_q      <= done_d;
      ur_q        <= ur_d;
    end
  end

  assign bus.s_ready       = s_ready;
  assign bus.sample_en     = sample_en;
  assign bus.lut_phase_rst = lut_q;
  assign bus.sym_out       = sym_q;
  assign bus.sym_strobe    = strobe_q;
  assign bus.tx_active     = (state_q == ST_PREAMBLE) || (state_q == ST_SYNC) ||
                             (state_q == ST_PAYLOAD);
  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.frame_done    = done_q;
  assign bus.underrun      = ur_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_qam_tx_sequencer.sv
// Bench for qam_tx_sequencer: frame-level model feeding an expected-symbol queue,
// with an independent monitor popping it on every sym_strobe.
module tb_qam_tx_sequencer;

  localparam int         PRESCALE      = 1;
  localparam int         SPS           = 4;
  localparam int         PREAMBLE_SYMS = 8;
  localparam logic [7:0] SYNC_WORD     = 8'hD3;
  localparam int         TAIL_SYMS     = 2;
  localparam int         SYM_CLKS      = SPS * (PRESCALE + 1);
  localparam int         W             = 3;   // {tx_active, sym_out}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  qam_if bus();

  qam_tx_sequencer #(
    .PRESCALE      (PRESCALE),
    .SPS           (SPS),
    .PREAMBLE_SYMS (PREAMBLE_SYMS),
    .SYNC_WORD     (SYNC_WORD),
    .TAIL_SYMS     (TAIL_SYMS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  logic [7:0]   pay_q[$];
  int n_vec = 0;
  int n_err = 0;

  int n_strobe = 0, n_done = 0, n_ur = 0, n_lut = 0, n_acc = 0, n_ready = 0, ur_at = 0;
  int last_strobe = 0;
  bit have_last = 1'b0;

  task automatic check(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, got, req, $time);
    end
  endtask

  function automatic int outs_now();
    return int'({bus.s_ready, bus.sample_en, bus.lut_phase_rst, bus.sym_out,
                 bus.sym_strobe, bus.tx_active, bus.busy, bus.frame_done, bus.underrun});
  endfunction

  // ---------------- monitor ----------------
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        have_last = 1'b0;
      end else begin
        if (bus.s_valid && bus.s_ready) n_acc++;
        if (bus.s_ready) n_ready++;
        if (bus.lut_phase_rst) begin
          n_lut++;
          have_last = 1'b0;
          check("lut_with_first_strobe", int'(bus.sym_strobe), 1);
        end
        if (bus.sym_strobe) begin
          n_strobe++;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_strobe: got sym_out=%b tx_active=%b, required no strobe",
                     bus.sym_out, bus.tx_active);
          end else begin
            exp = exp_q.pop_front();
            check("symbol", int'({bus.tx_active, bus.sym_out}), int'(exp));
          end
          if (have_last) check("strobe_gap", cyc - last_strobe, SYM_CLKS);
          have_last   = 1'b1;
          last_strobe = cyc;
        end
        if (bus.underrun) begin
          n_ur++;
          ur_at = n_strobe;
          check("underrun_with_strobe", int'(bus.sym_strobe), 1);
        end
        if (bus.frame_done) begin
          n_done++;
          check("done_gap", cyc - last_strobe, SYM_CLKS);
          check("done_queue_empty", exp_q.size(), 0);
          have_last = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int limit);
    int k = 0;
    while (bus.busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    check("idle_reached", int'(bus.busy), 0);
  endtask

  // Frame model: preamble, sync word, the bytes actually supplied, tail.
  task automatic push_frame(input int len, input int nb, output int total);
    logic [7:0] v;
    total = 0;
    for (int i = 0; i < PREAMBLE_SYMS; i++) begin
      exp_q.push_back({1'b1, (i % 2 == 0) ? 2'b10 : 2'b01});
      total++;
    end
    v = SYNC_WORD;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({1'b1, 2'((v >> (6 - 2 * i)) & 8'h3)});
      total++;
    end
    for (int b = 0; b < nb; b++) begin
      v = pay_q[b];
      for (int i = 0; i < 4; i++) begin
        exp_q.push_back({1'b1, 2'((v >> (6 - 2 * i)) & 8'h3)});
        total++;
      end
    end
    for (int i = 0; i < TAIL_SYMS; i++) begin
      exp_q.push_back({1'b0, 2'b00});
      total++;
    end
  endtask

  task automatic pulse_start(input int len);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.frame_len = 8'(len);
    @(negedge clk);
    bus.start     = 1'b0;
    bus.frame_len = 8'($urandom);
  endtask

  // One frame: len bytes requested, avail of them supplied, optional stray start in PAYLOAD.
  task automatic run_frame(input int len, input int avail, input bit repulse);
    int b_strobe, b_done, b_ur, b_lut, b_acc, b_ready;
    int nb, total, exp_ur, k;
    wait_idle(5000);
    nb     = (avail < len) ? avail : len;
    exp_ur = (avail < len) ? PREAMBLE_SYMS + 4 + 4 * avail + 1 : 0;
    push_frame(len, nb, total);
    b_strobe = n_strobe; b_done = n_done; b_ur = n_ur;
    b_lut = n_lut; b_acc = n_acc; b_ready = n_ready;
    pulse_start(len);
    for (int b = 0; b < nb; b++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = pay_q[b];
      k = 0;
      while (!bus.s_ready && k < 2000) begin
        @(negedge clk);
        k++;
      end
      check("ready_within_bound", int'(k < 2000), 1);
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_data  = 8'($urandom);
      if (k >= 2000) break;
      if (repulse && b == 1) begin
        bus.start     = 1'b1;
        bus.frame_len = 8'd5;
        @(negedge clk);
        bus.start     = 1'b0;
      end
    end
    wait_idle(20000);
    repeat (2) @(negedge clk);
    check("frame_done_count", n_done - b_done, 1);
    check("lut_phase_rst_count", n_lut - b_lut, 1);
    check("strobe_count", n_strobe - b_strobe, total);
    check("accept_count", n_acc - b_acc, nb);
    check("underrun_count", n_ur - b_ur, (exp_ur != 0) ? 1 : 0);
    if (exp_ur != 0) check("underrun_symbol", ur_at - b_strobe, exp_ur);
    if (len == 0) check("ready_never_seen", n_ready - b_ready, 0);
    check("queue_drained", exp_q.size(), 0);
    check("idle_outputs", int'({bus.tx_active, bus.sym_out}), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last, cnt, total, b_strobe, b_done, k;
    bus.start = 1'b0; bus.frame_len = '0; bus.s_data = '0; bus.s_valid = 1'b0;

    // 1: reset state and free-running sample_en
    repeat (3) @(negedge clk);
    check("reset_outputs", outs_now(), 0);
    rst = 1'b0;
    last = -1;
    cnt  = 0;
    for (int i = 0; i < 8 * (PRESCALE + 1); i++) begin
      @(negedge clk);
      if (bus.sample_en) begin
        if (last >= 0) check("sample_en_gap", i - last, PRESCALE + 1);
        last = i;
        cnt++;
      end
      check("idle_no_strobe", int'({bus.sym_strobe, bus.busy}), 0);
    end
    check("sample_en_count", cnt, 8);

    // 2: two-byte frame
    pay_q = '{8'h1B, 8'hE4};
    run_frame(2, 2, 1'b0);

    // 3: empty payload
    run_frame(0, 0, 1'b0);

    // 4: third byte withheld
    pay_q = '{8'hA5, 8'h3C, 8'h77};
    run_frame(3, 2, 1'b0);

    // 5: stray start during PAYLOAD
    pay_q = '{8'h1B, 8'hE4};
    run_frame(2, 2, 1'b1);

    // 6: reset in the middle of the sync word, then a full frame
    wait_idle(5000);
    push_frame(2, 2, total);
    b_strobe = n_strobe;
    b_done   = n_done;
    pulse_start(2);
    k = 0;
    while ((n_strobe - b_strobe) < PREAMBLE_SYMS + 2 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reached_sync", int'(k < 2000), 1);
    #2 rst = 1'b1;
    #1 check("async_reset_outputs", outs_now(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4 * SYM_CLKS) @(negedge clk);
    check("abort_no_frame_done", n_done - b_done, 0);
    check("abort_idle", int'(bus.busy), 0);
    run_frame(2, 2, 1'b0);

    // randomized frames, including the maximum length
    for (int r = 0; r < 6; r++) begin
      int len;
      len = (r == 5) ? 255 : $urandom_range(1, 24);
      pay_q.delete();
      for (int b = 0; b < len; b++) pay_q.push_back(8'($urandom));
      run_frame(len, len, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound in case a wait logic path misbehaves.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

endmodule
